// File: rtl/bubble_pkg.sv
// Shared types and constants for the in-place bubble sort engine and its data memory.
package bubble_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_CMP,
    S_WRA,
    S_WRB,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/bubble_cmp_swap.sv
// Single definition of the sort order (unsigned ascending): flags out-of-order pairs
// and presents the pair as lo/hi.
module bubble_cmp_swap #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gt,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  assign gt = (a > b);
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule

// File: rtl/bubble_sort_engine.sv
// In-place ascending bubble sort of N words at BASE in the data memory.
// Define SORT_EARLY_EXIT_EN to finish after the first pass that performs no swap.
module bubble_sort_engine
  import bubble_pkg::*;
#(
  parameter int N    = 10,
  parameter int BASE = 0,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_count,
  output logic [AW-1:0] address1,
  output logic [AW-1:0] address2,
  output logic [1:0]    mode,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_out
);

`ifdef SORT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam int IW = AW + 1;

  state_e        state_q, state_d;
  logic [IW-1:0] p_q, p_d, i_q, i_d;
  logic [DW-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic          swapped_q, swapped_d;
  logic [CW-1:0] swap_count_q, swap_count_d;

  logic [DW-1:0] cmp_b, cmp_lo, cmp_hi;
  logic          cmp_gt;
  logic [AW-1:0] addr_i, addr_i1;
  logic          more_in_pass, last_pass;

  // In CMP the second operand is still on the read bus; afterwards it lives in reg_b.
  assign cmp_b = (state_q == S_CMP) ? data_out : reg_b_q;

  bubble_cmp_swap #(.DW(DW)) u_cmp (
    .a  (reg_a_q),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lo (cmp_lo),
    .hi (cmp_hi)
  );

  assign addr_i       = AW'(BASE + int'(i_q));
  assign addr_i1      = AW'(BASE + int'(i_q) + 1);
  assign more_in_pass = (int'(i_q) + 1) < (N - 1 - int'(p_q));
  assign last_pass    = (int'(p_q) + 1) == (N - 1);
  assign swap_count   = swap_count_q;

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    i_d          = i_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;
    busy         = 1'b0;
    done         = 1'b0;
    mode         = MODE_READ;
    address1     = '0;
    address2     = '0;
    data_in      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d          = '0;
          i_d          = '0;
          swap_count_d = '0;
          swapped_d    = 1'b0;
          state_d      = (N < 2) ? S_FIN : S_RDA;
        end
      end
      S_RDA: begin
        busy     = 1'b1;
        address2 = addr_i;
        state_d  = S_RDB;
      end
      S_RDB: begin
        busy     = 1'b1;
        address2 = addr_i1;
        reg_a_d  = data_out;
        state_d  = S_CMP;
      end
      S_CMP: begin
        busy    = 1'b1;
        reg_b_d = data_out;
        state_d = cmp_gt ? S_WRA : S_NEXT;
      end
      S_WRA: begin
        busy     = 1'b1;
        address1 = addr_i;
        data_in  = cmp_lo;
        mode     = MODE_WRITE;
        state_d  = S_WRB;
      end
      S_WRB: begin
        busy      = 1'b1;
        address1  = addr_i1;
        data_in   = cmp_hi;
        mode      = MODE_WRITE;
        swapped_d = 1'b1;
        if (swap_count_q != '1) swap_count_d = swap_count_q + CW'(1);
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (more_in_pass) begin
          i_d     = i_q + IW'(1);
          state_d = S_RDA;
        end else begin
          i_d = '0;
          p_d = p_q + IW'(1);
          if (last_pass || (EARLY_EXIT && !swapped_q)) begin
            state_d = S_FIN;
          end else begin
            swapped_d = 1'b0;
            state_d   = S_RDA;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      i_q          <= '0;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      i_q          <= i_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
    end
  end

endmodule
